// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded BCD-style counter.
// Holds the direction encoding and the digit clamp helper.
package counter_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Limit a loaded digit value to the largest legal digit (radix-1).
    function automatic int unsigned clamp_digit(input int unsigned value,
                                                input int unsigned radix);
        clamp_digit = (value >= radix) ? (radix - 1) : value;
    endfunction

endpackage

// File: rtl/count_digit.sv
// One digit stage of the cascade counter: modulo-RADIX up/down digit with
// synchronous clear and load. The step enable comes from the carry chain.
module count_digit
    import counter_pkg::*;
#(
    parameter int RADIX = 10,
    localparam int DW = $clog2(RADIX)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          sclr,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          step_en,
    input  logic          up,
    output logic [DW-1:0] q,
    output logic          tc
);

    localparam logic [DW-1:0] MAX_DIGIT = DW'(RADIX - 1);

    logic [DW-1:0] load_val;

    // Clamp out-of-range load values to the top digit value.
    always_comb begin
        load_val = DW'(clamp_digit(32'(din), 32'(RADIX)));
    end

    // Terminal count for the current direction.
    always_comb begin
        tc = (up == DIR_UP) ? (q == MAX_DIGIT) : (q == '0);
    end

    // Digit register: clear, then load, then step, else hold.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (sclr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (step_en) begin
            if (up == DIR_UP) begin
                q <= (q == MAX_DIGIT) ? '0 : q + DW'(1);
            end else begin
                q <= (q == '0) ? MAX_DIGIT : q - DW'(1);
            end
        end
    end

endmodule

// File: rtl/cascade_counter.sv
// Cascaded multi-digit counter with parallel/trickle enables, ripple carry
// output and a registered wrap pulse.
// Optional macro CASCADE_COUNTER_DOWN_EN enables down counting via up_dn;
// without it up_dn is ignored and the block counts up only.
module cascade_counter
    import counter_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int RADIX  = 10,
    localparam int DW = $clog2(RADIX)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 sclr,
    input  logic                 enp,
    input  logic                 ent,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] din,
    input  logic                 up_dn,
    output logic [DIGITS*DW-1:0] qout,
    output logic                 rco,
    output logic                 wrap
);

    logic              count_en;
    logic              dir_up;
    logic [DIGITS-1:0] step_en;
    logic [DIGITS-1:0] tc;
    logic              all_tc;

`ifdef CASCADE_COUNTER_DOWN_EN
    assign dir_up = up_dn;
`else
    logic unused_up_dn;
    assign unused_up_dn = up_dn;
    assign dir_up       = DIR_UP;
`endif

    // Carry chain: a digit steps only when every lower digit is at terminal count.
    always_comb begin
        count_en   = enp & ent;
        step_en[0] = count_en;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            step_en[i] = step_en[i-1] & tc[i-1];
        end
        all_tc = &tc;
        rco    = ent & all_tc;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        count_digit #(
            .RADIX(RADIX)
        ) u_digit (
            .clk     (clk),
            .clr     (clr),
            .sclr    (sclr),
            .load    (load),
            .din     (din[g*DW +: DW]),
            .step_en (step_en[g]),
            .up      (dir_up),
            .q       (qout[g*DW +: DW]),
            .tc      (tc[g])
        );
    end

    // Wrap pulse: one cycle after a counting edge taken at full terminal count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wrap <= 1'b0;
        end else begin
            wrap <= count_en & all_tc & ~sclr & ~load;
        end
    end

endmodule

// File: tb/tb_cascade_counter.sv
// Directed bench for cascade_counter with DIGITS=3, RADIX=10.
// Expectations adapt to CASCADE_COUNTER_DOWN_EN where direction matters.
module tb_cascade_counter;

    logic        clk = 1'b0;
    logic        clr, sclr, enp, ent, load, up_dn;
    logic [11:0] din;
    logic [11:0] qout;
    logic        rco, wrap;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    cascade_counter #(
        .DIGITS(3),
        .RADIX(10)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .sclr  (sclr),
        .enp   (enp),
        .ent   (ent),
        .load  (load),
        .din   (din),
        .up_dn (up_dn),
        .qout  (qout),
        .rco   (rco),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [11:0] v);
        load = 1'b1;
        din  = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        clr = 1'b1; sclr = 1'b0; enp = 1'b0; ent = 1'b0;
        load = 1'b0; up_dn = 1'b1; din = '0;
        #3;
        check("reset_qout", 32'(qout), 32'h000);
        check("reset_wrap", 32'(wrap), 32'h0);
        ent = 1'b1;
        #1;
        check("reset_rco_up", 32'(rco), 32'h0);
        up_dn = 1'b0;
        #1;
`ifdef CASCADE_COUNTER_DOWN_EN
        check("reset_rco_dn", 32'(rco), 32'h1);
`else
        check("reset_rco_dn", 32'(rco), 32'h0);
`endif
        up_dn = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Count up to 345, then asynchronous clear between edges.
        enp = 1'b1; ent = 1'b1;
        ticks(345);
        check("count_345", 32'(qout), 32'h345);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async_qout", 32'(qout), 32'h000);
        check("clr_async_wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        clr = 1'b0;

        // Full period and wrap pulse.
        ticks(999);
        check("count_999", 32'(qout), 32'h999);
        check("rco_at_999", 32'(rco), 32'h1);
        check("no_wrap_yet", 32'(wrap), 32'h0);
        tick();
        check("wrap_to_000", 32'(qout), 32'h000);
        check("wrap_pulse", 32'(wrap), 32'h1);
        check("rco_after_wrap", 32'(rco), 32'h0);
        tick();
        check("count_001", 32'(qout), 32'h001);
        check("wrap_one_cycle", 32'(wrap), 32'h0);

        // Hold at 999 with enp low; rco follows ent only.
        enp = 1'b0;
        do_load(12'h999);
        check("load_999", 32'(qout), 32'h999);
        tick();
        check("hold_qout", 32'(qout), 32'h999);
        check("hold_rco", 32'(rco), 32'h1);
        check("hold_wrap", 32'(wrap), 32'h0);
        ent = 1'b0;
        #1;
        check("rco_ent_low", 32'(rco), 32'h0);
        enp = 1'b1;
        tick();
        check("hold_ent_low", 32'(qout), 32'h999);

        // Load has priority over count at terminal count: no wrap pulse.
        ent = 1'b1;
        do_load(12'h999);
        check("load_over_count", 32'(qout), 32'h999);
        check("load_no_wrap", 32'(wrap), 32'h0);

        // Clamp and sclr priority.
        enp = 1'b0;
        do_load(12'hC25);
        check("load_clamp", 32'(qout), 32'h925);
        do_load(12'h9FA);
        check("load_clamp_lo", 32'(qout), 32'h999);
        sclr = 1'b1;
        do_load(12'h456);
        sclr = 1'b0;
        check("sclr_over_load", 32'(qout), 32'h000);

        // Down count from 000.
        up_dn = 1'b0;
        #1;
`ifdef CASCADE_COUNTER_DOWN_EN
        check("rco_down_000", 32'(rco), 32'h1);
`else
        check("rco_down_000", 32'(rco), 32'h0);
`endif
        enp = 1'b1;
        tick();
`ifdef CASCADE_COUNTER_DOWN_EN
        check("down_wrap_q", 32'(qout), 32'h999);
        check("down_wrap_p", 32'(wrap), 32'h1);
`else
        check("down_wrap_q", 32'(qout), 32'h001);
        check("down_wrap_p", 32'(wrap), 32'h0);
`endif

        // Direction change with no dead cycle.
        enp = 1'b0;
        do_load(12'h099);
        enp = 1'b1;
        up_dn = 1'b0;
        tick();
`ifdef CASCADE_COUNTER_DOWN_EN
        check("dir_dn_step", 32'(qout), 32'h098);
`else
        check("dir_dn_step", 32'(qout), 32'h100);
`endif
        up_dn = 1'b1;
        tick();
`ifdef CASCADE_COUNTER_DOWN_EN
        check("dir_up_step", 32'(qout), 32'h099);
`else
        check("dir_up_step", 32'(qout), 32'h101);
`endif
        tick();
`ifdef CASCADE_COUNTER_DOWN_EN
        check("dir_up_carry", 32'(qout), 32'h100);
`else
        check("dir_up_carry", 32'(qout), 32'h102);
`endif

        // Borrow across two digits.
        enp = 1'b0;
        do_load(12'h100);
        enp = 1'b1;
        up_dn = 1'b0;
        tick();
`ifdef CASCADE_COUNTER_DOWN_EN
        check("down_borrow", 32'(qout), 32'h099);
`else
        check("down_borrow", 32'(qout), 32'h101);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cascade_counter.md
CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 3, meaning number of cascaded digit stages (1..8).
REQ-002 SHALL have parameter RADIX, default 10, meaning modulus of each digit (2..256).
REQ-003 SHALL have derived localparam DW = clog2(RADIX), meaning bits per digit; not overridable.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sclr  input  1  synchronous clear.
REQ-007 SHALL have port enp  input  1  parallel count enable.
REQ-008 SHALL have port ent  input  1  trickle count enable; also gates rco.
REQ-009 SHALL have port load  input  1  synchronous parallel load.
REQ-010 SHALL have port din  input  DIGITS*DW  load value; digit 0 occupies the LSBs.
REQ-011 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-012 SHALL have port qout  output  DIGITS*DW  count value; digit 0 occupies the LSBs.
REQ-013 SHALL have port rco  output  1  combinational ripple carry for cascading.
REQ-014 SHALL have port wrap  output  1  registered one-cycle wrap-around pulse.

Function
REQ-015 SHALL define count_en = enp & ent.
REQ-016 SHALL apply priority per clk edge: sclr, then load, then count, then hold.
REQ-017 SHALL set all digits to 0 and wrap to 0 on sclr.
REQ-018 SHALL load each digit from its din slice on load; a slice >= RADIX SHALL load RADIX-1.
REQ-019 SHALL, on count_en with up_dn=1, step digit i by +1 mod RADIX only when every digit below i equals RADIX-1.
REQ-020 SHALL, on count_en with up_dn=0, step digit i by -1 mod RADIX only when every digit below i equals 0.
REQ-021 SHALL define all_tc as all digits = RADIX-1 (up) or all digits = 0 (down), using the current up_dn.
REQ-022 SHALL drive rco = ent & all_tc combinationally; rco SHALL be independent of enp.
REQ-023 SHALL set wrap to 1 for exactly one cycle after an edge where count_en & all_tc & !sclr & !load held; otherwise wrap SHALL be 0.
REQ-024 SHALL apply an up_dn change at the next edge with no dead cycle.
REQ-025 SHALL hold qout and clear wrap when count_en=0 and no sclr or load is asserted.
REQ-026 SHALL produce a full period of RADIX^DIGITS counts; 999 up wraps to 000, and 000 down wraps to 999 (DIGITS=3, RADIX=10).
REQ-027 SHALL keep every digit within 0..RADIX-1 at all times.

Reset
REQ-028 SHALL, while clr=1, force qout to 0 and wrap to 0 immediately, independent of clk.
REQ-029 SHALL make rco follow REQ-022 during reset (rco = ent in down mode, 0 in up mode for qout=0, RADIX>1).
REQ-030 SHALL resume counting on the first clk edge after clr deasserts; a clr pulse mid-count SHALL discard the in-flight value.

Configuration
REQ-031 SHALL honour macro CASCADE_COUNTER_DOWN_EN: when defined, up_dn operates per REQ-011 and REQ-020.
REQ-032 SHALL, when CASCADE_COUNTER_DOWN_EN is undefined, keep the up_dn port but ignore it; the block counts up only and all_tc is all digits = RADIX-1.

Structure
REQ-033 SHALL place the direction encoding constants (DIR_UP=1, DIR_DN=0) and a digit-clamp function in shared package counter_pkg.
REQ-034 SHALL implement one digit as sub-module count_digit, with per-digit inputs step_en and up, outputs q and tc, and RADIX as its parameter.
REQ-035 SHALL generate DIGITS instances of count_digit; the top SHALL build the carry chain and the wrap register.

Verification (DIGITS=3, RADIX=10)
REQ-036 SHALL cover: clr=1 mid-count at qout=0x345 -> qout=0x000 and wrap=0 before the next clk edge.
REQ-037 SHALL cover: 999 edges up with enp=ent=1 -> qout=0x999 and rco=1; next edge -> qout=0x000, then wrap=1 for one cycle.
REQ-038 SHALL cover: qout=0x999, enp=0, ent=1 -> qout holds, rco=1, wrap=0; with ent=0 -> rco=0.
REQ-039 SHALL cover: load din=0xC25 -> qout=0x925 (top digit clamped); load and sclr together -> qout=0x000.
REQ-040 SHALL cover: with CASCADE_COUNTER_DOWN_EN defined, qout=0x000, up_dn=0, count -> 0x999 and wrap pulse; without the macro, the same stimulus -> 0x001.
REQ-041 SHALL cover: qout=0x099 with up_dn toggled to 0 for one edge -> 0x098, then back to 1 -> 0x099, then 0x100.
